// File: rtl/ram_ksa_engine_pkg.sv
// Shared types and helpers for the RC4 key-scheduling engine.
package ram_ksa_engine_pkg;

    // FSM state encoding; exported on state_tap for debug.
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_INIT_WR = 4'd1,
        S_ADDR_SI = 4'd2,
        S_WAIT_SI = 4'd3,
        S_CAP_SI  = 4'd4,
        S_WAIT_SJ = 4'd5,
        S_CAP_SJ  = 4'd6,
        S_WR_SI   = 4'd7,
        S_WR_SJ   = 4'd8,
        S_DONE    = 4'd9,
        S_ERR     = 4'd10
    } ksa_state_t;

    // Largest RAM read latency the wait counter is sized for.
    localparam int RD_LAT_MAX = 3;

    // Bit offset of key byte idx inside a packed key of nbytes bytes.
    // Byte 0 sits in the most significant slot.
    function automatic int key_byte_lsb(input int idx, input int nbytes, input int width);
        return (nbytes - 1 - idx) * width;
    endfunction

endpackage

// File: rtl/ram_ksa_engine_edge_detector.sv
// Rising-edge detector used to turn the start level into a single launch event.
module edge_detector (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // Remember the previous level of the input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/ram_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill of the S-box RAM followed
// by the full KSA swap loop, tolerant of a multi-cycle RAM read latency.
module ram_ksa_engine
    import ram_ksa_engine_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_KEY_BYTES = 3,
    parameter int RD_LAT        = 1
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     start,
    input  logic                                     init_en,
    input  logic                                     abort,
    input  logic [$clog2(MAX_KEY_BYTES+1)-1:0]       key_len,
    input  logic [MAX_KEY_BYTES*DATA_WIDTH-1:0]      key,
    input  logic [DATA_WIDTH-1:0]                    ram_rdata,
    output logic [ADDR_WIDTH-1:0]                    ram_addr,
    output logic [DATA_WIDTH-1:0]                    ram_wdata,
    output logic                                     ram_we,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err,
    output logic [ADDR_WIDTH-1:0]                    i_tap,
    output logic [ADDR_WIDTH-1:0]                    j_tap,
    output logic [3:0]                               state_tap
);

    localparam int KLW = $clog2(MAX_KEY_BYTES + 1);
    localparam int KW  = MAX_KEY_BYTES * DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] I_LAST      = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ONE_A       = ADDR_WIDTH'(1);
    localparam logic [KLW-1:0]        ONE_K       = KLW'(1);
    localparam logic [KLW-1:0]        KEY_LEN_MAX = KLW'(MAX_KEY_BYTES);
    localparam int                    WAIT_LAST_I = (RD_LAT > 1) ? (RD_LAT - 2) : 0;
    localparam logic [1:0]            WAIT_LAST   = 2'(WAIT_LAST_I);
    localparam logic [1:0]            ONE_W       = 2'd1;

    // Elaboration-time parameter sanity.
    if (DATA_WIDTH != ADDR_WIDTH) begin : g_bad_width
        $error("ram_ksa_engine: DATA_WIDTH must equal ADDR_WIDTH");
    end
    if ((RD_LAT < 1) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_lat
        $error("ram_ksa_engine: RD_LAT out of range");
    end

    ksa_state_t              state_q;
    logic [ADDR_WIDTH-1:0]   i_q;
    logic [ADDR_WIDTH-1:0]   j_q;
    logic [DATA_WIDTH-1:0]   si_q;
    logic [DATA_WIDTH-1:0]   sj_q;
    logic [KLW-1:0]          kidx_q;
    logic [KLW-1:0]          len_q;
    logic [KW-1:0]           key_q;
    logic [1:0]              wait_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic                    start_rise_s;
    logic [DATA_WIDTH-1:0]   key_byte_s;
    logic [ADDR_WIDTH-1:0]   j_d;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic [DATA_WIDTH-1:0]   wdata_s;
    logic                    we_s;

    edge_detector u_start_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (start),
        .rise_o  (start_rise_s)
    );

    // Current key byte and the candidate j computed while S[i] is on the read bus.
    assign key_byte_s = key_q[key_byte_lsb(int'(kidx_q), MAX_KEY_BYTES, DATA_WIDTH) +: DATA_WIDTH];
    assign j_d        = j_q + ram_rdata + key_byte_s;

    // Main sequencer: run acceptance, identity fill, read/swap loop, completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
            len_q   <= '0;
            key_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (abort) begin
            // Abort drops the run on the floor; RAM contents are left as they are.
            state_q <= S_IDLE;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_rise_s) begin
                        if ((key_len == '0) || (key_len > KEY_LEN_MAX)) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            key_q   <= key;
                            len_q   <= key_len;
                            i_q     <= '0;
                            j_q     <= '0;
                            kidx_q  <= '0;
                            wait_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= init_en ? S_INIT_WR : S_ADDR_SI;
                        end
                    end
                end
                S_INIT_WR: begin
                    if (i_q == I_LAST) begin
                        i_q     <= '0;
                        state_q <= S_ADDR_SI;
                    end else begin
                        i_q <= i_q + ONE_A;
                    end
                end
                S_ADDR_SI: begin
                    wait_q  <= '0;
                    state_q <= (RD_LAT == 1) ? S_CAP_SI : S_WAIT_SI;
                end
                S_WAIT_SI: begin
                    if (wait_q == WAIT_LAST) begin
                        wait_q  <= '0;
                        state_q <= S_CAP_SI;
                    end else begin
                        wait_q <= wait_q + ONE_W;
                    end
                end
                S_CAP_SI: begin
                    si_q    <= ram_rdata;
                    j_q     <= j_d;
                    wait_q  <= '0;
                    state_q <= (RD_LAT == 1) ? S_CAP_SJ : S_WAIT_SJ;
                end
                S_WAIT_SJ: begin
                    if (wait_q == WAIT_LAST) begin
                        wait_q  <= '0;
                        state_q <= S_CAP_SJ;
                    end else begin
                        wait_q <= wait_q + ONE_W;
                    end
                end
                S_CAP_SJ: begin
                    sj_q    <= ram_rdata;
                    state_q <= S_WR_SI;
                end
                S_WR_SI: begin
                    state_q <= S_WR_SJ;
                end
                S_WR_SJ: begin
                    if (i_q == I_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        i_q     <= i_q + ONE_A;
                        kidx_q  <= (kidx_q == (len_q - ONE_K)) ? '0 : (kidx_q + ONE_K);
                        state_q <= S_ADDR_SI;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // RAM port decode from the current state; the j read address follows j_d directly.
    always_comb begin
        addr_s  = '0;
        wdata_s = '0;
        we_s    = 1'b0;
        case (state_q)
            S_INIT_WR: begin
                we_s    = 1'b1;
                addr_s  = i_q;
                wdata_s = i_q;
            end
            S_ADDR_SI, S_WAIT_SI: begin
                addr_s = i_q;
            end
            S_CAP_SI: begin
                addr_s = j_d;
            end
            S_WAIT_SJ, S_CAP_SJ: begin
                addr_s = j_q;
            end
            S_WR_SI: begin
                we_s    = 1'b1;
                addr_s  = i_q;
                wdata_s = sj_q;
            end
            S_WR_SJ: begin
                we_s    = 1'b1;
                addr_s  = j_q;
                wdata_s = si_q;
            end
            default: begin
                addr_s  = '0;
                wdata_s = '0;
                we_s    = 1'b0;
            end
        endcase
    end

    // Abort must kill a write in the very cycle it is raised.
    assign ram_we    = we_s & ~abort;
    assign ram_addr  = addr_s;
    assign ram_wdata = wdata_s;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign i_tap     = i_q;
    assign j_tap     = j_q;
    assign state_tap = state_q;

endmodule
